// File: rtl/sudoku_pkg.sv
// Shared types and constants for the grid parser: cell encoding, ASCII codes,
// parser state/error enums and the box-index helper.
package sudoku_pkg;

    localparam int N     = 9;
    localparam int CELLS = 81;

    typedef logic [8:0] cell_t;

    localparam logic [7:0] ASCII_TAB   = 8'h09;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_ESC   = 8'h1B;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_COMMA = 8'h2C;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_ONE   = 8'h31;
    localparam logic [7:0] ASCII_NINE  = 8'h39;

    typedef enum logic [1:0] {
        COLLECT,
        DONE,
        ERROR
    } parse_state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_CHAR     = 2'd1,
        ERR_CONFLICT = 2'd2
    } parse_err_t;

    typedef enum logic [2:0] {
        CLS_DIGIT,
        CLS_EMPTY,
        CLS_SKIP,
        CLS_ABORT,
        CLS_ILLEGAL
    } byte_class_t;

    // Box number (Y/3)*3 + X/3 from coordinates 0..8, using compares instead of division.
    function automatic logic [3:0] box_index(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] band;
        logic [3:0] stack;
        band  = (y >= 4'd6) ? 4'd6 : ((y >= 4'd3) ? 4'd3 : 4'd0);
        stack = (x >= 4'd6) ? 4'd2 : ((x >= 4'd3) ? 4'd1 : 4'd0);
        return band + stack;
    endfunction

endpackage

// File: rtl/sudoku_grid_parser_if.sv
// Byte-in / grid-out bundle between the UART receiver side (master) and the
// grid parser (slave).
interface sudoku_grid_parser_if;

    logic [7:0]           i_Rx_Byte;
    logic                 i_Rx_Valid;
    logic                 i_Clear;
    sudoku_pkg::cell_t    o_Grid [9][9];
    logic                 o_Grid_Valid;
    logic                 o_Done;
    logic [1:0]           o_Error;
    logic [6:0]           o_Cell_Count;

    modport master (
        output i_Rx_Byte, i_Rx_Valid, i_Clear,
        input  o_Grid, o_Grid_Valid, o_Done, o_Error, o_Cell_Count
    );

    modport slave (
        input  i_Rx_Byte, i_Rx_Valid, i_Clear,
        output o_Grid, o_Grid_Valid, o_Done, o_Error, o_Cell_Count
    );

endinterface

// File: rtl/sudoku_char_decode.sv
// Combinational byte classifier: sorts a received byte into digit / empty /
// separator / abort / illegal and produces the one-hot cell value.
module sudoku_char_decode
    import sudoku_pkg::*;
#(
    parameter bit p_ALLOW_DOT = 1'b1
) (
    input  logic [7:0]  i_Byte,
    output byte_class_t o_Class,
    output cell_t       o_Value
);

    // NOTE: every output gets a default before the decision tree, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        o_Class = CLS_ILLEGAL;
        o_Value = '0;
        if (i_Byte >= ASCII_ONE && i_Byte <= ASCII_NINE) begin
            o_Class = CLS_DIGIT;
            o_Value = cell_t'(1) << (i_Byte[3:0] - 4'd1);
        end else if (i_Byte == ASCII_ZERO || (p_ALLOW_DOT && i_Byte == ASCII_DOT)) begin
            o_Class = CLS_EMPTY;
        end else if (i_Byte == ASCII_SPACE || i_Byte == ASCII_TAB || i_Byte == ASCII_CR ||
                     i_Byte == ASCII_LF || i_Byte == ASCII_COMMA) begin
            o_Class = CLS_SKIP;
        end else if (i_Byte == ASCII_ESC) begin
            o_Class = CLS_ABORT;
        end
    end

endmodule

// File: rtl/sudoku_grid_parser.sv
// Assembles the 81-cell one-hot puzzle grid from the received byte stream,
// tracking row/column/box masks to reject conflicting givens.
module sudoku_grid_parser
    import sudoku_pkg::*;
#(
    parameter bit p_ALLOW_DOT       = 1'b1,
    parameter bit p_CHECK_CONFLICTS = 1'b1
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_n,
    sudoku_grid_parser_if.slave  bus
);

    byte_class_t  byte_class;
    cell_t        byte_value;

    sudoku_char_decode #(
        .p_ALLOW_DOT (p_ALLOW_DOT)
    ) u_decode (
        .i_Byte  (bus.i_Rx_Byte),
        .o_Class (byte_class),
        .o_Value (byte_value)
    );

    parse_state_t state_q, state_d;
    parse_err_t   err_q, err_d;
    cell_t        grid_q [N][N];
    cell_t        grid_d [N][N];
    cell_t        row_mask_q [N];
    cell_t        row_mask_d [N];
    cell_t        col_mask_q [N];
    cell_t        col_mask_d [N];
    cell_t        box_mask_q [N];
    cell_t        box_mask_d [N];
    logic [3:0]   x_q, x_d;
    logic [3:0]   y_q, y_d;
    logic [6:0]   count_q, count_d;
    logic         valid_q, valid_d;
    logic         done_q, done_d;

    logic [3:0]   box_idx;
    logic         restart;
    logic         conflict;

    assign box_idx  = box_index(x_q, y_q);
    assign restart  = bus.i_Clear || (bus.i_Rx_Valid && byte_class == CLS_ABORT);
    assign conflict = p_CHECK_CONFLICTS &&
                      (|(byte_value & (row_mask_q[y_q] | col_mask_q[x_q] | box_mask_q[box_idx])));

    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        grid_d     = grid_q;
        row_mask_d = row_mask_q;
        col_mask_d = col_mask_q;
        box_mask_d = box_mask_q;
        x_d        = x_q;
        y_d        = y_q;
        count_d    = count_q;
        valid_d    = valid_q;
        done_d     = 1'b0;

        if (restart) begin
            state_d    = COLLECT;
            err_d      = ERR_NONE;
            grid_d     = '{default: '0};
            row_mask_d = '{default: '0};
            col_mask_d = '{default: '0};
            box_mask_d = '{default: '0};
            x_d        = '0;
            y_d        = '0;
            count_d    = '0;
            valid_d    = 1'b0;
        end else if (bus.i_Rx_Valid && state_q == COLLECT) begin
            if (byte_class == CLS_ILLEGAL) begin
                err_d   = ERR_CHAR;
                state_d = ERROR;
            end else if (byte_class == CLS_DIGIT && conflict) begin
                err_d   = ERR_CONFLICT;
                state_d = ERROR;
            end else if (byte_class == CLS_DIGIT || byte_class == CLS_EMPTY) begin
                // Empty cells carry value 0, so OR-ing it leaves the masks untouched.
                grid_d[x_q][y_q]    = byte_value;
                row_mask_d[y_q]     = row_mask_q[y_q] | byte_value;
                col_mask_d[x_q]     = col_mask_q[x_q] | byte_value;
                box_mask_d[box_idx] = box_mask_q[box_idx] | byte_value;
                count_d             = count_q + 7'd1;
                if (x_q == 4'd8) begin
                    x_d = '0;
                    y_d = y_q + 4'd1;
                end else begin
                    x_d = x_q + 4'd1;
                end
                if (count_q == 7'(CELLS - 1)) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                    done_d  = 1'b1;
                end
            end
        end
    end

    // NOTE: the grid is a bank of flops, not a RAM, so clearing it on reset is
    // required behaviour and costs nothing beyond the reset mux.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state_q    <= COLLECT;
            err_q      <= ERR_NONE;
            grid_q     <= '{default: '0};
            row_mask_q <= '{default: '0};
            col_mask_q <= '{default: '0};
            box_mask_q <= '{default: '0};
            x_q        <= '0;
            y_q        <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            grid_q     <= grid_d;
            row_mask_q <= row_mask_d;
            col_mask_q <= col_mask_d;
            box_mask_q <= box_mask_d;
            x_q        <= x_d;
            y_q        <= y_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
        end
    end

    assign bus.o_Grid       = grid_q;
    assign bus.o_Grid_Valid = valid_q;
    assign bus.o_Done       = done_q;
    assign bus.o_Error      = err_q;
    assign bus.o_Cell_Count = count_q;

endmodule

// File: tb/tb_sudoku_grid_parser.sv
// Directed bench for sudoku_grid_parser: legal grid, conflict, illegal char,
// abort/clear, dot handling and post-done/reset behaviour.
module tb_sudoku_grid_parser;

    logic clk;
    logic rst_n;
    int   total;
    int   passed;
    int   done_cnt;

    sudoku_grid_parser_if bus ();
    sudoku_grid_parser_if bus_nd ();

    sudoku_grid_parser dut (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .bus     (bus)
    );

    sudoku_grid_parser #(
        .p_ALLOW_DOT (1'b0)
    ) dut_nodot (
        .i_Clk   (clk),
        .i_Rst_n (rst_n),
        .bus     (bus_nd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.o_Done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.i_Rx_Byte  = b;
        bus.i_Rx_Valid = 1'b1;
        @(posedge clk);
        #1;
        bus.i_Rx_Valid = 1'b0;
    endtask

    task automatic send_nd(input logic [7:0] b);
        @(negedge clk);
        bus_nd.i_Rx_Byte  = b;
        bus_nd.i_Rx_Valid = 1'b1;
        @(posedge clk);
        #1;
        bus_nd.i_Rx_Valid = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        bus.i_Clear = 1'b1;
        @(posedge clk);
        #1;
        bus.i_Clear = 1'b0;
    endtask

    task automatic send_row(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send(s[i]);
            send(8'h20);
        end
        send(8'h0D);
        send(8'h0A);
    endtask

    function automatic logic [8:0] grid_or();
        logic [8:0] acc;
        acc = '0;
        for (int x = 0; x < 9; x++)
            for (int y = 0; y < 9; y++)
                acc = acc | bus.o_Grid[x][y];
        return acc;
    endfunction

    string puzzle [9];
    string last_row;

    initial begin
        puzzle[0] = "53..7....";
        puzzle[1] = "6..195...";
        puzzle[2] = ".98....6.";
        puzzle[3] = "8...6...3";
        puzzle[4] = "4..8.3..1";
        puzzle[5] = "7...2...6";
        puzzle[6] = ".6....28.";
        puzzle[7] = "...419..5";
        puzzle[8] = "....8..79";
        total = 0;
        passed = 0;
        done_cnt = 0;
        rst_n = 1'b0;
        bus.i_Rx_Byte = '0;
        bus.i_Rx_Valid = 1'b0;
        bus.i_Clear = 1'b0;
        bus_nd.i_Rx_Byte = '0;
        bus_nd.i_Rx_Valid = 1'b0;
        bus_nd.i_Clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", bus.o_Cell_Count, 0);
        check("rst_valid", bus.o_Grid_Valid, 0);
        check("rst_done", bus.o_Done, 0);
        check("rst_error", bus.o_Error, 0);
        check("rst_grid", grid_or(), 0);
        check("rst_nd_error", bus_nd.o_Error, 0);
        rst_n = 1'b1;

        // Legal puzzle with separators
        for (int r = 0; r < 8; r++) send_row(puzzle[r]);
        last_row = puzzle[8];
        for (int i = 0; i < 8; i++) begin
            send(last_row[i]);
            send(8'h20);
        end
        check("pre_last_count", bus.o_Cell_Count, 80);
        check("pre_last_done", bus.o_Done, 0);
        send("9");
        check("done_pulse", bus.o_Done, 1);
        check("done_count", bus.o_Cell_Count, 81);
        check("done_valid", bus.o_Grid_Valid, 1);
        send(8'h20);
        check("done_drop", bus.o_Done, 0);
        send(8'h0D);
        send(8'h0A);
        check("done_once", done_cnt, 1);
        check("cell_0_0", bus.o_Grid[0][0], 9'b000010000);
        check("cell_4_0", bus.o_Grid[4][0], 9'b001000000);
        check("cell_2_0_empty", bus.o_Grid[2][0], 0);
        check("cell_3_1", bus.o_Grid[3][1], 9'b000000001);
        check("cell_8_8", bus.o_Grid[8][8], 9'b100000000);
        check("cell_0_8_empty", bus.o_Grid[0][8], 0);
        check("done_error", bus.o_Error, 0);

        // Bytes after DONE are ignored
        for (int i = 0; i < 10; i++) send(8'h31 + 8'(i % 9));
        check("post_done_count", bus.o_Cell_Count, 81);
        check("post_done_valid", bus.o_Grid_Valid, 1);
        check("post_done_cell", bus.o_Grid[0][0], 9'b000010000);
        check("post_done_cell88", bus.o_Grid[8][8], 9'b100000000);
        check("post_done_pulses", done_cnt, 1);

        // One-edge reset clears everything
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst2_count", bus.o_Cell_Count, 0);
        check("rst2_valid", bus.o_Grid_Valid, 0);
        check("rst2_grid", grid_or(), 0);
        check("rst2_error", bus.o_Error, 0);

        // Row conflict on cell 17
        send_row("53..7....");
        send_row("6..195..5");
        check("conf_error", bus.o_Error, 2);
        check("conf_count", bus.o_Cell_Count, 17);
        check("conf_cell_8_1", bus.o_Grid[8][1], 0);
        check("conf_cell_5_1", bus.o_Grid[5][1], 9'b000010000);
        check("conf_valid", bus.o_Grid_Valid, 0);
        send("1");
        send("2");
        check("conf_ignore_count", bus.o_Cell_Count, 17);
        check("conf_ignore_cell", bus.o_Grid[0][2], 0);
        send(8'h1B);
        check("esc_from_err_count", bus.o_Cell_Count, 0);
        check("esc_from_err_error", bus.o_Error, 0);

        // Illegal character as the third byte
        send("1");
        send("2");
        send("A");
        check("illegal_error", bus.o_Error, 1);
        check("illegal_count", bus.o_Cell_Count, 2);
        send(8'h1B);
        check("esc_error", bus.o_Error, 0);
        check("esc_count", bus.o_Cell_Count, 0);
        check("esc_grid", grid_or(), 0);
        check("esc_valid", bus.o_Grid_Valid, 0);
        check("esc_done", bus.o_Done, 0);
        send("4");
        check("collect_again_count", bus.o_Cell_Count, 1);
        check("collect_again_cell", bus.o_Grid[0][0], 9'b000001000);

        // Clear beats a simultaneous byte
        for (int i = 0; i < 39; i++) send("0");
        check("forty_count", bus.o_Cell_Count, 40);
        @(negedge clk);
        bus.i_Rx_Byte  = "7";
        bus.i_Rx_Valid = 1'b1;
        bus.i_Clear    = 1'b1;
        @(posedge clk);
        #1;
        bus.i_Rx_Valid = 1'b0;
        bus.i_Clear    = 1'b0;
        check("clear_count", bus.o_Cell_Count, 0);
        check("clear_grid", grid_or(), 0);
        check("clear_error", bus.o_Error, 0);
        send("7");
        check("after_clear_cell", bus.o_Grid[0][0], 9'b001000000);

        // Dot handling in both parameterisations
        pulse_clear();
        send(".");
        check("dot_count", bus.o_Cell_Count, 1);
        check("dot_error", bus.o_Error, 0);
        check("dot_cell", bus.o_Grid[0][0], 0);
        send_nd(".");
        check("nodot_error", bus_nd.o_Error, 1);
        check("nodot_count", bus_nd.o_Cell_Count, 0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sudoku_grid_parser.md
Name: sudoku_grid_parser

Overview:
- Upstream stage of the solver: consumes the byte stream from the UART receiver and assembles the 81-cell one-hot puzzle grid the scanner consumes.
- Decodes ASCII digits, skips separators, validates the givens for row/column/box conflicts, and flags when a complete, legal grid is held.
- Output grid is registered and stable from o_Grid_Valid until cleared.

Parameters:
- p_ALLOW_DOT, 1: when 1, '.' (0x2E) is an empty cell like '0'; when 0, '.' is an illegal character.
- p_CHECK_CONFLICTS, 1: when 1, a given that duplicates a digit already in its row, column or 3x3 box raises a conflict error.

Ports:
- i_Clk  in  1  system clock.
- i_Rst_n  in  1  synchronous reset, active low.
- i_Rx_Byte  in  8  received byte, qualified by i_Rx_Valid.
- i_Rx_Valid  in  1  one-cycle strobe per received byte.
- i_Clear  in  1  one-cycle strobe: discard the grid and restart collection.
- o_Grid  out  81x9 (unpacked [8:0][8:0] of 9-bit)  one-hot cells indexed [X][Y]; 0 means empty.
- o_Grid_Valid  out  1  level: a complete, error-free grid is held.
- o_Done  out  1  one-cycle pulse when the 81st cell is accepted.
- o_Error  out  2  0 none, 1 illegal char, 2 conflict; sticky.
- o_Cell_Count  out  7  cells accepted so far, 0..81.

Behaviour:
- Reset (i_Rst_n=0 at an edge):
  - All o_Grid cells, o_Grid_Valid, o_Done, o_Error and o_Cell_Count go to 0.
  - Row, column and box masks clear.
  - State goes to COLLECT.
- Byte classes:
  - '1'..'9' (0x31..0x39): digit d maps to one-hot bit d-1.
  - '0', and '.' when p_ALLOW_DOT=1: empty cell, value 0.
  - Space, TAB, CR, LF, ',': skip; no state change, not counted.
  - ESC (0x1B): abort.
  - Anything else: illegal.
- Cell order is row-major. Cell k goes to X = k%9, Y = k/9, box = (Y/3)*3 + X/3. X and Y come from separate counters (0..8), not division.
- States:
  - COLLECT:
    - Digit or empty byte: write the cell and increment the count on the next edge.
    - Digit with p_CHECK_CONFLICTS=1 and its bit already set in row[Y] | col[X] | box[b]: the cell is not written, o_Error<=2, go to ERROR. Otherwise OR the bit into all three masks.
    - Illegal byte: o_Error<=1, go to ERROR.
    - Accepting cell 80 (count goes 80->81): on the same edge go to DONE, o_Grid_Valid<=1, o_Done<=1. o_Done drops after one cycle.
  - DONE: all bytes ignored except ESC; the grid holds.
  - ERROR: all bytes ignored except ESC; the partial grid holds; o_Grid_Valid stays 0.
- Abort and clear:
  - ESC in any state, or i_Clear, has the same effect as reset on the next edge, except o_Done stays 0.
  - i_Clear together with i_Rx_Valid: clear wins and the byte is dropped.
- Latency: one edge from i_Rx_Valid to the o_Grid / o_Cell_Count update. The parser accepts a byte every cycle, with no backpressure.
- The empty-cell value 0 never touches the masks.
- Reset mid-grid discards everything; there is no resumption.

Decomposition:
- sudoku_pkg holds:
  - typedef cell_t (logic[8:0]).
  - Constants N=9, CELLS=81.
  - ASCII constants (ESC, '0', '.', separators).
  - enum parse_state_t {COLLECT, DONE, ERROR}.
  - enum parse_err_t {ERR_NONE, ERR_CHAR, ERR_CONFLICT}.
- Sub-module sudoku_char_decode: combinational, i_Byte -> class (DIGIT/EMPTY/SKIP/ABORT/ILLEGAL) plus the one-hot cell value, honouring p_ALLOW_DOT.

Test Plan:
- Reset, then 81 bytes of a legal puzzle with a CR LF after every 9 and spaces between → o_Done pulses once, exactly one cycle, the edge after the 81st digit; o_Cell_Count=81; o_Grid[0][0]=9'b000010000 for '5'; empty cells are 0; o_Error=0.
- Row 0 = "53..7...." then row 1 beginning "6..195..5" → conflict on the second '5' in row 1 (cell 17) → o_Error=2, o_Cell_Count=17, cell [8][1] stays 0, o_Grid_Valid=0. Later bytes are ignored.
- 'A' (0x41) as byte 3 → o_Error=1, o_Cell_Count=2. ESC next → all outputs 0, state COLLECT.
- 40 cells, then i_Clear asserted in the same cycle as i_Rx_Valid with '7' → count 0, grid all zero, '7' not stored.
- p_ALLOW_DOT=0: '.' as the first byte → o_Error=1. With the default, '.' yields an empty cell and count 1.
- After DONE, send 10 more digits → o_Grid, o_Cell_Count and o_Grid_Valid unchanged and no further o_Done. i_Rst_n low for one edge → everything returns to 0.
